// File: rtl/player_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : player_ctrl
// Description : Tile-stepping player block controller. Four raw push buttons
//               are synchronized and debounced. Once per video frame the
//               block steps STEP pixels. A move that starts from a tile
//               boundary always runs to the next tile boundary, whatever the
//               buttons do meanwhile.
// Ports       : i_clk            pixel clock
//               i_rst            asynchronous active-high reset
//               i_up/down/left/right  raw asynchronous buttons, active-high
//               i_curr_x/i_curr_y current scan position from the VGA timing
//               o_blkpos_x/y     block top-left position (registered)
//               o_moving         high while a tile move is in progress
//               o_frame_tick     one-clock pulse once per frame
// Revision    : 1.0 - initial release
// ============================================================================
module player_ctrl #(
    parameter int SCREEN_W  = 1280,
    parameter int SCREEN_H  = 800,
    parameter int TILE      = 32,
    parameter int STEP      = 4,
    parameter int INIT_X    = 32,
    parameter int INIT_Y    = 32,
    parameter int DB_CYCLES = 840000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_up,
    input  logic        i_down,
    input  logic        i_left,
    input  logic        i_right,
    input  logic [10:0] i_curr_x,
    input  logic [9:0]  i_curr_y,
    output logic [10:0] o_blkpos_x,
    output logic [9:0]  o_blkpos_y,
    output logic        o_moving,
    output logic        o_frame_tick
);

    localparam int          c_CNT_W  = $clog2(DB_CYCLES + 1);
    localparam logic [0:0]  c_IDLE   = 1'b0;
    localparam logic [0:0]  c_MOVE   = 1'b1;
    localparam logic [1:0]  c_DIR_UP    = 2'd0;
    localparam logic [1:0]  c_DIR_DOWN  = 2'd1;
    localparam logic [1:0]  c_DIR_LEFT  = 2'd2;
    localparam logic [1:0]  c_DIR_RIGHT = 2'd3;
    // Position arithmetic is one bit wider than the ports so that a step
    // past either edge is visible to the bound checks instead of wrapping.
    localparam logic [11:0] c_X_MAX  = 12'(SCREEN_W - TILE);
    localparam logic [10:0] c_Y_MAX  = 11'(SCREEN_H - TILE);
    localparam logic [11:0] c_STEP_X = 12'(STEP);
    localparam logic [10:0] c_STEP_Y = 11'(STEP);
    localparam logic [11:0] c_TILE_X = 12'(TILE);
    localparam logic [10:0] c_TILE_Y = 11'(TILE);

    // Button bit order everywhere: {right, left, down, up}
    logic [3:0]  w_raw;
    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [3:0]  w_db;

    logic        w_at_h;
    logic        r_at_h_d;
    logic        r_frame_tick;

    logic [0:0]  r_state;
    logic [0:0]  w_next_state;
    logic [1:0]  r_dir;
    logic [10:0] r_x;
    logic [9:0]  r_y;

    logic [1:0]  w_btn_dir;
    logic        w_btn_any;
    logic [1:0]  w_act_dir;
    logic [11:0] w_x_wide;
    logic [10:0] w_y_wide;
    logic [11:0] w_cand_x;
    logic [10:0] w_cand_y;
    logic        w_in_bounds;
    logic        w_aligned;
    logic        w_start;
    logic        w_do_step;

    // Horizontal scan position is not needed: the frame boundary is defined
    // purely by the line counter.
    logic        w_unused_curr_x;
    assign w_unused_curr_x = ^i_curr_x;

    assign w_raw = {i_right, i_left, i_down, i_up};

    // ------------------------------------------------------------------
    // Two-flop synchronizers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Debouncers: the debounced level follows the synced level only after
    // DB_CYCLES consecutive disagreeing clocks.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 4; g++) begin : g_db
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_level;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
            end else if (r_sync2[g] == r_level) begin
                r_cnt   <= '0;
            end else if (r_cnt == c_CNT_W'(DB_CYCLES - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync2[g];
            end else begin
                r_cnt   <= r_cnt + 1'b1;
            end
        end

        assign w_db[g] = r_level;
    end

    // ------------------------------------------------------------------
    // Frame tick: registered rising edge of (curr_y == SCREEN_H), so it
    // fires once even if the line value is held for many clocks.
    // ------------------------------------------------------------------
    assign w_at_h = (i_curr_y == 10'(SCREEN_H));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_at_h_d     <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_at_h_d     <= w_at_h;
            r_frame_tick <= w_at_h & ~r_at_h_d;
        end
    end

    // ------------------------------------------------------------------
    // Candidate step and legality
    // ------------------------------------------------------------------
    always_comb begin
        w_btn_dir = c_DIR_UP;
        w_btn_any = 1'b1;
        if (w_db[0])      w_btn_dir = c_DIR_UP;
        else if (w_db[1]) w_btn_dir = c_DIR_DOWN;
        else if (w_db[2]) w_btn_dir = c_DIR_LEFT;
        else if (w_db[3]) w_btn_dir = c_DIR_RIGHT;
        else              w_btn_any = 1'b0;

        // During a move the buttons are ignored entirely.
        w_act_dir   = (r_state == c_MOVE) ? r_dir : w_btn_dir;
        w_x_wide    = {1'b0, r_x};
        w_y_wide    = {1'b0, r_y};
        w_cand_x    = w_x_wide;
        w_cand_y    = w_y_wide;
        w_in_bounds = 1'b0;
        w_aligned   = 1'b0;

        case (w_act_dir)
            c_DIR_UP: begin
                w_cand_y    = w_y_wide - c_STEP_Y;
                w_in_bounds = (w_y_wide >= c_STEP_Y);
                w_aligned   = ((w_cand_y % c_TILE_Y) == '0);
            end
            c_DIR_DOWN: begin
                w_cand_y    = w_y_wide + c_STEP_Y;
                w_in_bounds = (w_cand_y <= c_Y_MAX);
                w_aligned   = ((w_cand_y % c_TILE_Y) == '0);
            end
            c_DIR_LEFT: begin
                w_cand_x    = w_x_wide - c_STEP_X;
                w_in_bounds = (w_x_wide >= c_STEP_X);
                w_aligned   = ((w_cand_x % c_TILE_X) == '0);
            end
            default: begin
                w_cand_x    = w_x_wide + c_STEP_X;
                w_in_bounds = (w_cand_x <= c_X_MAX);
                w_aligned   = ((w_cand_x % c_TILE_X) == '0);
            end
        endcase
    end

    assign w_start   = r_frame_tick && (r_state == c_IDLE) && w_btn_any && w_in_bounds;
    assign w_do_step = w_start || (r_frame_tick && (r_state == c_MOVE));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
                    w_next_state = c_MOVE;
                end
            end
            default: begin
                if (r_frame_tick && w_aligned) begin
                    w_next_state = c_IDLE;
                end
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_moving = (r_state == c_MOVE);
    end

    // ------------------------------------------------------------------
    // Position and latched direction; only updated on the frame tick so
    // the drawing block never sees a change mid-frame.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x   <= 11'(INIT_X);
            r_y   <= 10'(INIT_Y);
            r_dir <= c_DIR_UP;
        end else begin
            if (w_do_step) begin
                r_x <= w_cand_x[10:0];
                r_y <= w_cand_y[9:0];
            end
            if (w_start) begin
                r_dir <= w_btn_dir;
            end
        end
    end

    assign o_blkpos_x   = r_x;
    assign o_blkpos_y   = r_y;
    assign o_frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_player_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_ctrl
// Description : Self-checking bench for player_ctrl. A frame-level reference
//               model predicts block position, moving flag and frame tick;
//               a compare process checks them every clock. Directed
//               scenarios pin the model with literal values, then a
//               randomized phase exercises button patterns, glitches and
//               resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_ctrl;

    localparam int SW   = 1280;
    localparam int SH   = 800;
    localparam int TILE = 32;
    localparam int STEP = 4;
    localparam int IX   = 32;
    localparam int IY   = 32;
    localparam int DB   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic [10:0] cx = '0;
    logic [9:0]  cy = '0;
    logic [10:0] blk_x;
    logic [9:0]  blk_y;
    logic        moving;
    logic        frame_tick;

    player_ctrl #(
        .SCREEN_W (SW),
        .SCREEN_H (SH),
        .TILE     (TILE),
        .STEP     (STEP),
        .INIT_X   (IX),
        .INIT_Y   (IY),
        .DB_CYCLES(DB)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_up        (up),
        .i_down      (down),
        .i_left      (left),
        .i_right     (right),
        .i_curr_x    (cx),
        .i_curr_y    (cy),
        .o_blkpos_x  (blk_x),
        .o_blkpos_y  (blk_y),
        .o_moving    (moving),
        .o_frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int tick_cnt = 0;

    // Reference model state. m_btn is the settled button vector
    // {right, left, down, up} that the block must see at the next tick.
    int       m_x = IX;
    int       m_y = IY;
    bit       m_moving = 1'b0;
    int       m_dir = 0;
    bit       exp_tick = 1'b0;
    bit [3:0] m_btn = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // One frame of the behavioural model: positions as plain integers.
    task automatic model_frame();
        int d;
        int nx;
        int ny;
        d = m_moving ? m_dir : -1;
        if (!m_moving) begin
            if (m_btn[0])      d = 0;
            else if (m_btn[1]) d = 1;
            else if (m_btn[2]) d = 2;
            else if (m_btn[3]) d = 3;
        end
        if (d < 0) return;
        nx = m_x;
        ny = m_y;
        case (d)
            0: ny = ny - STEP;
            1: ny = ny + STEP;
            2: nx = nx - STEP;
            default: nx = nx + STEP;
        endcase
        if (!m_moving) begin
            if (nx >= 0 && nx <= SW - TILE && ny >= 0 && ny <= SH - TILE) begin
                m_dir    = d;
                m_x      = nx;
                m_y      = ny;
                m_moving = 1'b1;
            end
        end else begin
            m_x = nx;
            m_y = ny;
            if (((d < 2) ? (ny % TILE) : (nx % TILE)) == 0) m_moving = 1'b0;
        end
    endtask

    // Every-cycle comparison against the model.
    initial begin
        @(posedge clk);
        forever begin
            @(posedge clk);
            #2;
            chk("blkpos_x", int'(blk_x), m_x);
            chk("blkpos_y", int'(blk_y), m_y);
            chk("moving", int'(moving), int'(m_moving));
            chk("frame_tick", int'(frame_tick), int'(exp_tick));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (frame_tick) tick_cnt++;
        end
    end

    task automatic set_raw(input bit [3:0] v);
        {right, left, down, up} = v;
    endtask

    task automatic press(input bit [3:0] v, input int settle);
        @(negedge clk);
        set_raw(v);
        repeat (settle) @(negedge clk);
        m_btn = v;
    endtask

    // Raise curr_y to SCREEN_H for 'hold' clocks; the model steps on the
    // clock where the DUT's tick is high, which is when the DUT's position
    // registers load.
    task automatic frame(input int hold);
        @(negedge clk);
        cy = 10'(SH);
        exp_tick = 1'b1;
        @(negedge clk);
        exp_tick = 1'b0;
        model_frame();
        for (int i = 1; i < hold; i++) @(negedge clk);
        cy = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_raw(4'b0000);
        rst = 1'b1;
        m_x = IX;
        m_y = IY;
        m_moving = 1'b0;
        m_dir = 0;
        m_btn = '0;
        exp_tick = 1'b0;
        #1;
        chk("rst_x", int'(blk_x), 32);
        chk("rst_y", int'(blk_y), 32);
        chk("rst_moving", int'(moving), 0);
        chk("rst_tick", int'(frame_tick), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1;
        do_reset();

        // Right held, then 8 ticks: x 36..64, moving through tick 8 only.
        press(4'b1000, 20);
        for (int k = 1; k <= 8; k++) begin
            frame(1);
            chk("r018_x", int'(blk_x), 32 + 4 * k);
            chk("r018_y", int'(blk_y), 32);
            chk("r018_moving", int'(moving), (k < 8) ? 1 : 0);
        end
        press(4'b0000, 12);
        frame(1);
        chk("r018_after_x", int'(blk_x), 64);

        // Short right pulse below the debounce window: no move.
        do_reset();
        @(negedge clk);
        set_raw(4'b1000);
        repeat (3) @(negedge clk);
        set_raw(4'b0000);
        repeat (10) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            frame(2);
            chk("r019_x", int'(blk_x), 32);
            chk("r019_moving", int'(moving), 0);
        end

        // Up+left from (32,32): up wins, then blocked at the top edge.
        do_reset();
        press(4'b0101, 20);
        frame(1);
        chk("r020_y1", int'(blk_y), 28);
        for (int k = 2; k <= 8; k++) frame(1);
        chk("r020_y8", int'(blk_y), 0);
        chk("r020_x8", int'(blk_x), 32);
        chk("r020_mov8", int'(moving), 0);
        press(4'b0001, 12);
        frame(1);
        frame(1);
        chk("r020_blocked_y", int'(blk_y), 0);
        chk("r020_blocked_mov", int'(moving), 0);

        // Down released after tick 1: the move still completes.
        do_reset();
        press(4'b0010, 20);
        frame(1);
        chk("r021_y1", int'(blk_y), 36);
        press(4'b0000, 12);
        for (int k = 2; k <= 8; k++) frame(1);
        chk("r021_y8", int'(blk_y), 64);
        chk("r021_mov8", int'(moving), 0);
        frame(1);
        chk("r021_idle_y", int'(blk_y), 64);

        // Reset mid-move aborts and returns to the initial position.
        do_reset();
        press(4'b1000, 20);
        for (int k = 1; k <= 3; k++) frame(1);
        chk("r022_x3", int'(blk_x), 44);
        chk("r022_mov3", int'(moving), 1);
        do_reset();
        frame(1);
        chk("r022_after_x", int'(blk_x), 32);
        chk("r022_after_mov", int'(moving), 0);

        // curr_y held at SCREEN_H for 500 clocks: one tick only.
        tick_cnt = 0;
        frame(500);
        chk("r023_tick_count", tick_cnt, 1);

        // Randomized phase.
        do_reset();
        for (int it = 0; it < 250; it++) begin
            bit [3:0] v;
            bit [3:0] g;
            int       k;
            v = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            press(v, 12);
            if ($urandom_range(0, 3) == 0) begin
                g = 4'($urandom_range(0, 15));
                k = $urandom_range(1, 3);
                @(negedge clk);
                set_raw(g);
                repeat (k) @(negedge clk);
                set_raw(v);
                repeat (8) @(negedge clk);
            end
            frame($urandom_range(1, 4));
            if ($urandom_range(0, 39) == 0) do_reset();
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
